// File: rtl/snake_game_ctrl.sv
// Snake game sequencing controller: worm, item, size and score registers advanced once per move tick.
// Optional SNAKE_WRAP_EN: a head stepping onto the border reappears on the opposite playfield edge.
module snake_game_ctrl #(
    parameter int unsigned MAX_SIZE  = 20,
    parameter int unsigned TICK_DIV  = 2_500_000,
    parameter int unsigned INIT_SIZE = 3
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_start,
    input  logic                  i_up,
    input  logic                  i_down,
    input  logic                  i_left,
    input  logic                  i_right,
    output logic [MAX_SIZE*6-1:0] o_worm_x,
    output logic [MAX_SIZE*6-1:0] o_worm_y,
    output logic [5:0]            o_item_x,
    output logic [5:0]            o_item_y,
    output logic [19:0]           o_size,
    output logic [7:0]            o_score,
    output logic                  o_game_over
);
    localparam int unsigned W_POS   = 6;
    localparam int unsigned W_SLOTS = MAX_SIZE * W_POS;
    localparam int unsigned W_SIZE  = 20;
    localparam int unsigned W_LFSR  = 12;
    localparam int unsigned W_CNT   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W_LFSR-1:0] LFSR_SEED = 12'hACE;
    localparam logic [W_POS-1:0]  ROW_LAST  = 6'd47;
    localparam logic [W_POS-1:0]  COL_LAST  = 6'd63;
    localparam logic [W_POS-1:0]  ROW_MAX   = 6'd46;
    localparam logic [W_POS-1:0]  COL_MAX   = 6'd62;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_CHECK, S_PLACE, S_OVER, S_INIT} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t            state, state_nxt;
    dir_t              dir, pend_dir, req_dir;
    logic              req_valid;
    logic [W_CNT-1:0]  tick_cnt;
    logic              tick_pend, tick_run, tick_term;
    logic [W_LFSR-1:0] lfsr;
    logic              lfsr_fb;
    logic [W_POS-1:0]  head_x, head_y, step_x, step_y, nh_x, nh_y, cand_x, cand_y;
    logic              eat, border, self_hit, cand_ok;
    logic [W_SIZE-1:0] hit_limit;

    function automatic logic [W_SLOTS-1:0] init_rows();
        logic [W_SLOTS-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < MAX_SIZE; j++)
            if (j < INIT_SIZE) v[j*W_POS +: W_POS] = 6'd24;
        return v;
    endfunction

    function automatic logic [W_SLOTS-1:0] init_cols();
        logic [W_SLOTS-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < MAX_SIZE; j++)
            if (j < INIT_SIZE) v[j*W_POS +: W_POS] = W_POS'(32 - j);
        return v;
    endfunction

    assign head_x    = o_worm_x[W_POS-1:0];
    assign head_y    = o_worm_y[W_POS-1:0];
    assign lfsr_fb   = lfsr[11] ^ lfsr[10] ^ lfsr[9] ^ lfsr[3];
    assign tick_run  = state inside {S_RUN, S_STEP, S_CHECK, S_PLACE};
    assign tick_term = (tick_cnt == W_CNT'(TICK_DIV - 1));
    assign cand_x    = lfsr[5:0];
    assign cand_y    = lfsr[11:6];

    // Button priority up > down > left > right; a reversal of the committed heading is dropped.
    always_comb begin
        req_valid = 1'b1;
        req_dir   = DIR_RIGHT;
        if (i_up)         req_dir = DIR_UP;
        else if (i_down)  req_dir = DIR_DOWN;
        else if (i_left)  req_dir = DIR_LEFT;
        else if (i_right) req_dir = DIR_RIGHT;
        else              req_valid = 1'b0;
        if (req_dir == dir_t'({dir[1], ~dir[0]})) req_valid = 1'b0;
    end

    always_comb begin
        step_x = head_x;
        step_y = head_y;
        case (pend_dir)
            DIR_UP:    step_x = head_x - 6'd1;
            DIR_DOWN:  step_x = head_x + 6'd1;
            DIR_LEFT:  step_y = head_y - 6'd1;
            DIR_RIGHT: step_y = head_y + 6'd1;
        endcase
`ifdef SNAKE_WRAP_EN
        if (step_x == '0)            step_x = ROW_MAX;
        else if (step_x == ROW_LAST) step_x = 6'd1;
        if (step_y == '0)            step_y = COL_MAX;
        else if (step_y == COL_LAST) step_y = 6'd1;
`endif
    end

    // Tail slot vacates on a plain move, so it is excluded from the self-hit range.
    always_comb begin
        eat = (nh_x == o_item_x) && (nh_y == o_item_y);
`ifdef SNAKE_WRAP_EN
        border = 1'b0;
`else
        border = (nh_x == '0) || (nh_x == ROW_LAST) || (nh_y == '0) || (nh_y == COL_LAST);
`endif
        hit_limit = (eat && (o_size < W_SIZE'(MAX_SIZE))) ? o_size : o_size - W_SIZE'(1);
        self_hit  = 1'b0;
        cand_ok   = (cand_x >= 6'd1) && (cand_x <= ROW_MAX) && (cand_y >= 6'd1) && (cand_y <= COL_MAX);
        for (int unsigned j = 0; j < MAX_SIZE; j++) begin
            if ((W_SIZE'(j) < hit_limit) && (o_worm_x[j*W_POS +: W_POS] == nh_x)
                && (o_worm_y[j*W_POS +: W_POS] == nh_y))
                self_hit = 1'b1;
            if ((W_SIZE'(j) < o_size) && (o_worm_x[j*W_POS +: W_POS] == cand_x)
                && (o_worm_y[j*W_POS +: W_POS] == cand_y))
                cand_ok = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = S_RUN;
            S_RUN:   if (tick_pend) state_nxt = S_STEP;
            S_STEP:  state_nxt = S_CHECK;
            S_CHECK: begin
                if (border || self_hit) state_nxt = S_OVER;
                else if (eat)           state_nxt = S_PLACE;
                else                    state_nxt = S_RUN;
            end
            S_PLACE: if (cand_ok) state_nxt = S_RUN;
            S_OVER:  if (i_start) state_nxt = S_INIT;
            S_INIT:  state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            lfsr        <= LFSR_SEED;
            tick_cnt    <= '0;
            tick_pend   <= 1'b0;
            dir         <= DIR_RIGHT;
            pend_dir    <= DIR_RIGHT;
            nh_x        <= '0;
            nh_y        <= '0;
            o_worm_x    <= init_rows();
            o_worm_y    <= init_cols();
            o_item_x    <= 6'd10;
            o_item_y    <= 6'd10;
            o_size      <= W_SIZE'(INIT_SIZE);
            o_score     <= '0;
            o_game_over <= 1'b0;
        end else begin
            lfsr <= {lfsr[W_LFSR-2:0], lfsr_fb};
            // A tick arriving outside RUN stays pending until RUN consumes it.
            if (tick_run) begin
                if (tick_term) begin
                    tick_cnt  <= '0;
                    tick_pend <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + W_CNT'(1);
                    if (state == S_RUN) tick_pend <= 1'b0;
                end
            end else begin
                tick_cnt  <= '0;
                tick_pend <= 1'b0;
            end
            if (req_valid) pend_dir <= req_dir;
            case (state)
                S_STEP: begin
                    nh_x <= step_x;
                    nh_y <= step_y;
                    dir  <= pend_dir;
                end
                S_CHECK: begin
                    if (border || self_hit) begin
                        o_game_over <= 1'b1;
                    end else begin
                        o_worm_x <= {o_worm_x[W_SLOTS-W_POS-1:0], nh_x};
                        o_worm_y <= {o_worm_y[W_SLOTS-W_POS-1:0], nh_y};
                        if (eat) begin
                            if (o_size < W_SIZE'(MAX_SIZE)) o_size <= o_size + W_SIZE'(1);
                            if (o_score != 8'hFF)          o_score <= o_score + 8'd1;
                        end
                    end
                end
                S_PLACE: begin
                    if (cand_ok) begin
                        o_item_x <= cand_x;
                        o_item_y <= cand_y;
                    end
                end
                S_INIT: begin
                    dir         <= DIR_RIGHT;
                    pend_dir    <= DIR_RIGHT;
                    o_worm_x    <= init_rows();
                    o_worm_y    <= init_cols();
                    o_item_x    <= 6'd10;
                    o_item_y    <= 6'd10;
                    o_size      <= W_SIZE'(INIT_SIZE);
                    o_score     <= '0;
                    o_game_over <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed scoreboard bench for snake_game_ctrl: a 4-slot and a 5-slot initial worm on a fast move tick.
// Honours SNAKE_WRAP_EN for the border scenario.
module tb_snake_game_ctrl;
    localparam int unsigned MAX_SIZE = 20;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned W        = MAX_SIZE * 6;

    logic clk = 1'b0;
    logic rst_n, start4, start5, btn_up, btn_down, btn_left, btn_right;
    logic [W-1:0] wx4, wy4, wx5, wy5, obs_wx, obs_wy;
    logic [5:0]   ix4, iy4, ix5, iy5, obs_ix, obs_iy, obs_hx, obs_hy;
    logic [19:0]  size4, size5, obs_size;
    logic [7:0]   score4, score5, obs_score;
    logic         go4, go5, obs_go;
    logic         sel;
    int           n_assert, n_fail;

    typedef struct {
        string       tag;
        logic [5:0]  hx, hy;
        logic [19:0] size;
        logic [7:0]  score;
        logic        go;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    snake_game_ctrl #(.MAX_SIZE(MAX_SIZE), .TICK_DIV(TICK_DIV), .INIT_SIZE(4)) dut (
        .i_Clk(clk), .i_Rst(rst_n), .i_start(start4),
        .i_up(btn_up), .i_down(btn_down), .i_left(btn_left), .i_right(btn_right),
        .o_worm_x(wx4), .o_worm_y(wy4), .o_item_x(ix4), .o_item_y(iy4),
        .o_size(size4), .o_score(score4), .o_game_over(go4));

    snake_game_ctrl #(.MAX_SIZE(MAX_SIZE), .TICK_DIV(TICK_DIV), .INIT_SIZE(5)) dut5 (
        .i_Clk(clk), .i_Rst(rst_n), .i_start(start5),
        .i_up(btn_up), .i_down(btn_down), .i_left(btn_left), .i_right(btn_right),
        .o_worm_x(wx5), .o_worm_y(wy5), .o_item_x(ix5), .o_item_y(iy5),
        .o_size(size5), .o_score(score5), .o_game_over(go5));

    always_comb begin
        if (sel) begin
            obs_wx = wx5; obs_wy = wy5; obs_ix = ix5; obs_iy = iy5;
            obs_size = size5; obs_score = score5; obs_go = go5;
        end else begin
            obs_wx = wx4; obs_wy = wy4; obs_ix = ix4; obs_iy = iy4;
            obs_size = size4; obs_score = score4; obs_go = go4;
        end
    end
    assign obs_hx = obs_wx[5:0];
    assign obs_hy = obs_wy[5:0];

    function automatic logic [5:0] sx(input int k);
        return obs_wx[k*6 +: 6];
    endfunction
    function automatic logic [5:0] sy(input int k);
        return obs_wy[k*6 +: 6];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits for the head or game-over flag to change; cyc is the number of cycles it took.
    task automatic wait_update(input int budget, output int cyc);
        logic [5:0] hx0, hy0;
        logic       go0;
        hx0 = obs_hx; hy0 = obs_hy; go0 = obs_go;
        cyc = 0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (obs_hx !== hx0 || obs_hy !== hy0 || obs_go !== go0) return;
        end
        n_assert++;
        n_fail++;
        $error("FAIL update_timeout observed=none expected=change within %0d cycles", budget);
    endtask

    task automatic move(input string tag, input int hx, input int hy, input int sz,
                        input int sc, input logic go, input int exp_cyc);
        exp_t e;
        int   cyc;
        e.tag = tag; e.hx = 6'(hx); e.hy = 6'(hy); e.size = 20'(sz); e.score = 8'(sc); e.go = go;
        sb.push_back(e);
        wait_update(16, cyc);
        e = sb.pop_front();
        chk({e.tag, "_head_x"}, obs_hx, e.hx);
        chk({e.tag, "_head_y"}, obs_hy, e.hy);
        chk({e.tag, "_size"}, obs_size, e.size);
        chk({e.tag, "_score"}, obs_score, e.score);
        chk({e.tag, "_game_over"}, obs_go, e.go);
        if (exp_cyc > 0) chk({e.tag, "_cycles"}, cyc, exp_cyc);
    endtask

    task automatic pulse(input logic u, input logic d, input logic l, input logic r,
                         input logic s4, input logic s5);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r; start4 = s4; start5 = s5;
        @(negedge clk);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; start4 = 0; start5 = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        n_assert = 0; n_fail = 0; sel = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; start4 = 0; start5 = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_head_x", obs_hx, 24);
        chk("rst_head_y", obs_hy, 32);
        chk("rst_slot1_y", sy(1), 31);
        chk("rst_slot3_y", sy(3), 29);
        chk("rst_slot4_x", sx(4), 0);
        chk("rst_slot4_y", sy(4), 0);
        chk("rst_item_x", obs_ix, 10);
        chk("rst_item_y", obs_iy, 10);
        chk("rst_size", obs_size, 4);
        chk("rst_score", obs_score, 0);
        chk("rst_game_over", obs_go, 0);
        chk("rst_size5", size5, 5);
        rst_n = 1;
        repeat (8) @(negedge clk);
        chk("idle_hold_y", obs_hy, 32);

        // Straight run, priority and reversal filtering, then steer onto the item at (10,10).
        pulse(0, 0, 0, 0, 1, 0);
        move("first", 24, 33, 4, 0, 0, 7);
        chk("first_slot1_y", sy(1), 32);
        move("second", 24, 34, 4, 0, 0, 4);
        move("third", 24, 35, 4, 0, 0, 4);
        pulse(1, 0, 1, 0, 0, 0);
        move("prio_up", 23, 35, 4, 0, 0, 0);
        pulse(0, 1, 0, 0, 0, 0);
        move("down_ignored", 22, 35, 4, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 25; k++) move("left_run", 22, 35 - k, 4, 0, 0, (k == 1) ? 0 : 4);
        pulse(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 11; k++) move("up_run", 22 - k, 10, 4, 0, 0, 0);
        move("eat", 10, 10, 5, 1, 0, 0);
        chk("eat_tail_x", sx(4), 14);
        chk("eat_tail_y", sy(4), 10);
        c = 0;
        while (obs_ix == 6'd10 && obs_iy == 6'd10 && c < 64) begin
            @(negedge clk);
            c++;
        end
        chk("item_moved", (obs_ix != 6'd10) || (obs_iy != 6'd10), 1);
        chk("item_row_range", (obs_ix >= 6'd1) && (obs_ix <= 6'd46), 1);
        chk("item_col_range", (obs_iy >= 6'd1) && (obs_iy <= 6'd62), 1);
        chk("item_off_worm", (obs_iy != 6'd10) || (obs_ix < 6'd10) || (obs_ix > 6'd14), 1);

        // Second eat, then asynchronous reset while placing the new item.
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        pulse(0, 0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 14; k++) move("b_up", 24 - k, 32, 4, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 21; k++) move("b_left", 10, 32 - k, 4, 0, 0, 0);
        move("b_eat", 10, 10, 5, 1, 0, 0);
        rst_n = 0;
        #1;
        chk("place_rst_head_x", obs_hx, 24);
        chk("place_rst_head_y", obs_hy, 32);
        chk("place_rst_slot1_y", sy(1), 31);
        chk("place_rst_slot4_x", sx(4), 0);
        chk("place_rst_item_x", obs_ix, 10);
        chk("place_rst_item_y", obs_iy, 10);
        chk("place_rst_size", obs_size, 4);
        chk("place_rst_score", obs_score, 0);
        chk("place_rst_game_over", obs_go, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (6) @(negedge clk);
        chk("place_rst_idle_y", obs_hy, 32);
        pulse(0, 0, 0, 0, 1, 0);
        move("resume", 24, 33, 4, 0, 0, 7);
        for (int k = 2; k <= 30; k++) move("right_run", 24, 32 + k, 4, 0, 0, 4);
`ifdef SNAKE_WRAP_EN
        move("wrap", 24, 1, 4, 0, 0, 4);
`else
        move("wall", 24, 62, 4, 0, 1, 4);
        repeat (12) @(negedge clk);
        chk("frozen_head_y", obs_hy, 62);
        chk("frozen_slot1_y", sy(1), 61);
        chk("frozen_size", obs_size, 4);
        chk("frozen_game_over", obs_go, 1);
        pulse(0, 0, 0, 0, 1, 0);
        move("restart_init", 24, 32, 4, 0, 0, 1);
        move("restart_first", 24, 33, 4, 0, 0, 7);
`endif

        // Four-slot worm turns into the cell its tail is leaving.
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        pulse(0, 0, 0, 0, 1, 0);
        pulse(1, 0, 0, 0, 0, 0);
        move("tail_up", 23, 32, 4, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        move("tail_left", 23, 31, 4, 0, 0, 0);
        pulse(0, 1, 0, 0, 0, 0);
        move("tail_vacate", 24, 31, 4, 0, 0, 0);
        move("tail_after", 25, 31, 4, 0, 0, 4);

        // Five-slot worm turns into its own body.
        sel = 1;
        rst_n = 0;
        #1;
        chk("self_rst_slot4_y", sy(4), 28);
        @(negedge clk);
        rst_n = 1;
        pulse(0, 0, 0, 0, 0, 1);
        pulse(1, 0, 0, 0, 0, 0);
        move("self_up", 23, 32, 5, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        move("self_left", 23, 31, 5, 0, 0, 0);
        pulse(0, 1, 0, 0, 0, 0);
        move("self_hit", 23, 31, 5, 0, 1, 0);
        repeat (8) @(negedge clk);
        chk("self_frozen_x", obs_hx, 23);
        chk("self_frozen_go", obs_go, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-sequencing controller for the snake display path. Owns the worm segment registers, item position and worm length, and advances them at a fixed move tick from direction button pulses. Detects wall, self and item collisions, grows the worm and places new items with an LFSR. Its outputs drive the VGA renderer's `i_worm_x/i_worm_y/i_item_x/i_item_y/i_size` inputs directly.

## Interface
- `MAX_SIZE`, 20: number of segment slots. Must match the renderer.
- `TICK_DIV`, 2_500_000: `i_Clk` cycles per move tick.
- `INIT_SIZE`, 3: worm length after reset or restart. Range 2..`MAX_SIZE`.

Ports:
- `i_Clk` in 1: system clock. One clock domain; reset is asynchronous, active-low.
- `i_Rst` in 1: asynchronous active-low reset.
- `i_start` in 1: one-cycle pulse. Starts from IDLE, restarts from OVER.
- `i_up` / `i_down` / `i_left` / `i_right` in 1 each: one-cycle, already-debounced direction pulses.
- `o_worm_x` out `MAX_SIZE*6`: segment rows, 6 bits per slot; slot 0 is the head. Row maps to the vertical axis.
- `o_worm_y` out `MAX_SIZE*6`: segment columns, 6 bits per slot. Column maps to the horizontal axis.
- `o_item_x` / `o_item_y` out 6 each: item row and column.
- `o_size` out 20: current worm length.
- `o_score` out 8: items eaten, saturating at 255.
- `o_game_over` out 1: high while in OVER.

## Operation
**Grid**
- 48 rows × 64 columns. Row 0, row 47, column 0 and column 63 are the border.
- Playfield is rows 1..46, columns 1..62.

**Reset / INIT values**
- Head at (24,32), body at (24,31) and (24,30), continuing leftward for `INIT_SIZE`. All unused slots are 0.
- `dir` = RIGHT.
- Item at (10,10).
- `o_size` = `INIT_SIZE`, `o_score` = 0, `o_game_over` = 0.
- State after reset: IDLE.

**States**
- IDLE: wait for `i_start`, then go to RUN.
- RUN: wait for `tick_pend`, then go to STEP and clear `tick_pend`.
- STEP: compute `nh` = head + delta(`pend_dir`), then commit `dir` <= `pend_dir`. Go to CHECK.
- CHECK:
  - `nh` on the border, or `nh` equals any segment in the compare range: go to OVER with no register update.
  - Otherwise shift every slot (slot j <= slot j-1) and set slot 0 <= `nh`.
  - If `eat` (`nh` == item): `o_size` += 1 (saturating at `MAX_SIZE`), `o_score` += 1, then go to PLACE.
  - Else go to RUN.
  - Compare range: slots 0..size-2 when not eating, because the tail vacates; slots 0..size-1 when eating with size < `MAX_SIZE`.
- PLACE: one candidate per cycle, row = `lfsr[5:0]`, column = `lfsr[11:6]`.
  - Accept if row is in 1..46, column is in 1..62, and the candidate is not on any slot j < `o_size`.
  - On accept: update the item and go to RUN. Otherwise retry on the next cycle.
- OVER: all outputs hold. `i_start` goes to INIT.
- INIT: reload the reset values, except the LFSR keeps running. Go to RUN.

**Direction**
- `pend_dir` loads from a button pulse in any state.
- Simultaneous pulses resolve by priority: up > down > left > right.
- A request opposite to the committed `dir` is ignored.
- The last accepted request before STEP wins.

**Tick and LFSR**
- Tick counter counts 0..`TICK_DIV`-1 in RUN, STEP, CHECK and PLACE. It is cleared in IDLE, OVER and INIT.
- Terminal count sets the one-deep `tick_pend`.
- LFSR: 12 bits, taps 12,11,10,4, seed 12'hACE. Advances every cycle from reset and never reaches zero.

## Timing
- Button-to-`pend_dir` latency: 1 cycle.
- Tick to outputs updated: 3 cycles (RUN→STEP→CHECK; registers update at the CHECK exit edge).
- Item update happens at least 1 cycle after the CHECK edge, in PLACE.
- Steady move period: exactly `TICK_DIV` cycles. A tick that lands in STEP/CHECK/PLACE is held in `tick_pend`, not lost.
- Slot registers beyond `o_size` are shifted like the others and are don't-care to the renderer.
- Reset mid-game: asynchronous return to reset values and IDLE.

## Configuration
- `SNAKE_WRAP_EN` defined:
  - Border is not fatal. A head stepping onto row 0 becomes row 46; row 47 becomes row 1; column 0 becomes column 62; column 63 becomes column 1.
  - Only self-collision ends the game.
- `SNAKE_WRAP_EN` undefined: border hit → OVER.

## Test plan
- Reset, `i_start`, no buttons, `TICK_DIV`=4:
  - After the first tick, head = (24,33), `o_size`=3.
  - Successive moves are 4 cycles apart.
- Direction RIGHT, pulse `i_left` then `i_up` in the same cycle:
  - `i_up` wins; next move gives head (23,x).
  - Pulse `i_down` alone while going up: ignored.
- Place item at (24,33) via force, then tick:
  - `o_size`=4, `o_score`=1.
  - New item is inside the playfield and off the worm within ≤64 cycles.
- Run right to column 62, then tick:
  - Without macro: `o_game_over`=1 and outputs frozen.
  - With `SNAKE_WRAP_EN`: head column = 1.
- Size-5 worm turning up/left/down into its own body:
  - `o_game_over`=1.
  - Moving into the cell the tail vacates that tick does not end the game.
- Assert `i_Rst` mid-PLACE, then release:
  - All outputs at INIT values and state IDLE.
  - `i_start` then resumes correctly.
